axis_gate_packer: RTL and testbench

Gated stream packetizer that sits directly downstream of the sample countdown timer. It consumes the timer's `trg_flag` as `gate_flag` and forwards a sample stream only while the gate is high. Each gate-high window is closed into one AXI-Stream packet, with `tlast` on the final forwarded beat. Beats forwarded per window are reported on `sts_data` for the PS.

---
 rtl/axis_gate_pkg.sv | 17 +
 rtl/axis_gate_outreg.sv | 36 +++
 rtl/axis_gate_packer.sv | 133 +++++++++++++
 tb/tb_axis_gate_packer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gate_pkg.sv
// Shared types and helpers for the gated stream packetizer.
package axis_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } gate_state_t;

    localparam int unsigned SAT_MAX_WIDTH = 64;

    // All-ones value of a counter 'width' bits wide (width <= SAT_MAX_WIDTH).
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_max(input int unsigned width);
        return {SAT_MAX_WIDTH{1'b1}} >> (SAT_MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/axis_gate_outreg.sv
// Output register O of the gated packetizer: one AXI-Stream slot with
// load port and the "slot free" indication used for input back-pressure.
module axis_gate_outreg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  ofree
);

    assign ofree = ~m_axis_tvalid | m_axis_tready;

    // Load wins over drain; a handshake without reload empties the slot.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
            m_axis_tlast  <= load_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_gate_packer.sv
// Gated AXI-Stream packetizer: forwards samples only while gate_flag is high
// and reports the number of accepted beats per window on sts_data.
// Optional feature macro: AXIS_GATE_PACKER_TLAST_EN adds a hold register and
// a FLUSH state so the final beat of each window carries tlast.
module axis_gate_packer
    import axis_gate_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        gate_flag,
    output logic                        busy,
    output logic [CNTR_WIDTH-1:0]       sts_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = CNTR_WIDTH'(sat_max(CNTR_WIDTH));

    gate_state_t                 state;
    logic [CNTR_WIDTH-1:0]       cnt;
    logic                        ofree;
    logic                        accept;
    logic                        o_load;
    logic [AXIS_TDATA_WIDTH-1:0] o_data;
    logic                        o_last;

    assign sts_data = cnt;
    assign accept   = s_axis_tvalid & s_axis_tready;

`ifdef AXIS_GATE_PACKER_TLAST_EN
    logic                        h_valid;
    logic [AXIS_TDATA_WIDTH-1:0] h_data;
    logic                        flush_go;

    // Holding one beat back lets the window close with tlast on the real last beat.
    assign s_axis_tready = (state == PASS) & gate_flag & (~h_valid | ofree);
    assign flush_go      = (state == FLUSH) & ofree;
    assign o_load        = flush_go | (accept & h_valid);
    assign o_data        = h_data;
    assign o_last        = flush_go;

    // Hold register H: captures each accepted beat, emptied by the flush.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            h_valid <= 1'b0;
            h_data  <= '0;
        end else if (accept) begin
            h_valid <= 1'b1;
            h_data  <= s_axis_tdata;
        end else if (flush_go) begin
            h_valid <= 1'b0;
        end
    end
`else
    assign s_axis_tready = (state == PASS) & gate_flag & ofree;
    assign o_load        = accept;
    assign o_data        = s_axis_tdata;
    assign o_last        = 1'b0;
`endif

    // Window FSM with registered busy and the saturating beat counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNTR_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (gate_flag) begin
                        state <= PASS;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                PASS: begin
                    if (!gate_flag) begin
`ifdef AXIS_GATE_PACKER_TLAST_EN
                        if (h_valid) begin
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef AXIS_GATE_PACKER_TLAST_EN
                FLUSH: begin
                    if (ofree) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    axis_gate_outreg #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH)
    ) u_outreg (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .load         (o_load),
        .load_data    (o_data),
        .load_last    (o_last),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .ofree        (ofree)
    );

endmodule

// File: tb/tb_axis_gate_packer.sv
// Self-checking bench for axis_gate_packer (4-bit counter to reach saturation).
// Expectations follow AXIS_GATE_PACKER_TLAST_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_axis_gate_packer;

`ifdef AXIS_GATE_PACKER_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        gate_flag;
    logic        busy;
    logic [3:0]  sts_data;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int unsigned n;
        logic [31:0] base;
        bit          bp;
        int unsigned exp_beats;
        logic [31:0] exp_sts;
        logic [31:0] exp_last_data;
    } vec_t;

    beat_t got_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    axis_gate_packer #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH      (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .gate_flag    (gate_flag),
        .busy         (busy),
        .sts_data     (sts_data),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // Output monitor: records every completed output handshake.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            got_q.push_back('{data: m_axis_tdata, last: m_axis_tlast});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Presents n consecutive beats starting at base, bounded by a cycle budget.
    task automatic push_beats(input int unsigned n, input logic [31:0] base);
        int unsigned acc = 0;
        int unsigned cyc = 0;
        bit hs;
        s_axis_tvalid = (n != 0);
        s_axis_tdata  = base;
        while (acc < n && cyc < 50) begin
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            tick();
            cyc++;
            if (hs) begin
                acc++;
                s_axis_tdata = base + acc;
                if (acc == n) s_axis_tvalid = 1'b0;
            end
        end
        s_axis_tvalid = 1'b0;
        check("push_accepted", acc, n);
    endtask

    // One full window: gate high until all beats accepted (min 3 cycles), then drain.
    task automatic apply_vec(input vec_t v);
        int unsigned acc = 0;
        int unsigned cyc = 0;
        bit hs;
        got_q.delete();
        gate_flag     = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = (v.n != 0);
        s_axis_tdata  = v.base;
        while ((acc < v.n || cyc < 3) && cyc < 200) begin
            if (v.bp) m_axis_tready = ~cyc[0];
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            tick();
            cyc++;
            if (hs) begin
                acc++;
                s_axis_tdata = v.base + acc;
                if (acc == v.n) s_axis_tvalid = 1'b0;
            end
        end
        check("win_accepted", acc, v.n);
        gate_flag     = 1'b0;
        s_axis_tvalid = 1'b0;
        cyc = 0;
        while ((busy || m_axis_tvalid) && cyc < 200) begin
            if (v.bp) m_axis_tready = ~cyc[0];
            tick();
            cyc++;
        end
        m_axis_tready = 1'b1;
        tick();
        @(negedge aclk);
        check("win_drain_in_budget", 32'(cyc < 200), 32'd1);
        check("win_busy_idle", 32'(busy), 32'd0);
        check("win_sts", 32'(sts_data), v.exp_sts);
        check("win_beat_count", 32'(got_q.size()), v.exp_beats);
        for (int i = 0; i < got_q.size() && i < int'(v.n); i++) begin
            check("win_beat_data", got_q[i].data, v.base + 32'(i));
            check("win_beat_last", 32'(got_q[i].last), 32'(TLAST_EN && (i == int'(v.n) - 1)));
        end
        if (got_q.size() > 0)
            check("win_final_data", got_q[got_q.size()-1].data, v.exp_last_data);
        tick();
    endtask

    initial begin
        vec_t vecs[4];
        vec_t clean;
        int   nb;
        int   n_last;

        vecs[0] = '{n: 4,  base: 32'h10,  bp: 1'b0, exp_beats: 4,  exp_sts: 32'd4,  exp_last_data: 32'h13};
        vecs[1] = '{n: 0,  base: 32'h0,   bp: 1'b0, exp_beats: 0,  exp_sts: 32'd0,  exp_last_data: 32'h0};
        vecs[2] = '{n: 6,  base: 32'hA0,  bp: 1'b1, exp_beats: 6,  exp_sts: 32'd6,  exp_last_data: 32'hA5};
        vecs[3] = '{n: 20, base: 32'h100, bp: 1'b0, exp_beats: 20, exp_sts: 32'd15, exp_last_data: 32'h113};

        aresetn       = 1'b0;
        gate_flag     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        @(negedge aclk);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
        check("rst_m_tdata",  m_axis_tdata,       32'd0);
        check("rst_busy",     32'(busy),          32'd0);
        check("rst_sts",      32'(sts_data),      32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) apply_vec(vecs[k]);

        // Empty window: busy drops one cycle after the gate falls.
        gate_flag = 1'b1;
        tick();
        tick();
        @(negedge aclk);
        check("empty_busy_high", 32'(busy), 32'd1);
        tick();
        gate_flag = 1'b0;
        @(negedge aclk);
        check("empty_busy_still", 32'(busy), 32'd1);
        tick();
        @(negedge aclk);
        check("empty_busy_low", 32'(busy), 32'd0);
        tick();

        // Beat offered in the gate-fall cycle is refused; final beat timing.
        got_q.delete();
        gate_flag = 1'b1;
        tick();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h31;
        tick();
        s_axis_tdata  = 32'h32;
        tick();
        gate_flag    = 1'b0;
        s_axis_tdata = 32'hEE;
        @(negedge aclk);
        check("fall_s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("fall_o_empty", 32'(m_axis_tvalid), 32'd0);
        tick();
        @(negedge aclk);
        check("fall_last_valid", 32'(m_axis_tvalid), 32'(TLAST_EN));
        check("fall_last_flag",  32'(m_axis_tlast),  32'(TLAST_EN));
        check("fall_last_data",  m_axis_tdata,       32'h32);
        check("fall_busy",       32'(busy),          32'd0);
        tick();
        tick();
        check("fall_beats", 32'(got_q.size()), 32'd2);
        check("fall_sts",   32'(sts_data),     32'd2);
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            check("fall_beat_data", got_q[i].data, 32'h31 + 32'(i));
            check("fall_beat_last", 32'(got_q[i].last), 32'(TLAST_EN && i == 1));
        end

        // Gate re-rises while the closing beat is stalled by back-pressure.
        got_q.delete();
        nb = TLAST_EN ? 2 : 1;
        m_axis_tready = 1'b0;
        gate_flag     = 1'b1;
        tick();
        push_beats(nb, 32'h41);
        gate_flag = 1'b0;
        tick();
        gate_flag = 1'b1;
        tick();
        tick();
        tick();
        @(negedge aclk);
        check("rise_busy_stalled", 32'(busy), 32'd1);
        check("rise_o_held_valid", 32'(m_axis_tvalid), 32'd1);
        check("rise_o_held_data",  m_axis_tdata, 32'h41);
        tick();
        m_axis_tready = 1'b1;
        tick();
        tick();
        tick();
        @(negedge aclk);
        check("rise_new_sts", 32'(sts_data), 32'd0);
        check("rise_new_busy", 32'(busy), 32'd1);
        check("rise_beats", 32'(got_q.size()), 32'(nb));
        for (int i = 0; i < got_q.size() && i < nb; i++) begin
            check("rise_beat_data", got_q[i].data, 32'h41 + 32'(i));
            check("rise_beat_last", 32'(got_q[i].last), 32'(TLAST_EN && i == nb - 1));
        end
        tick();
        got_q.delete();
        push_beats(1, 32'h51);
        gate_flag = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        @(negedge aclk);
        check("rise_win2_sts", 32'(sts_data), 32'd1);
        check("rise_win2_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            check("rise_win2_data", got_q[0].data, 32'h51);
            check("rise_win2_last", 32'(got_q[0].last), 32'(TLAST_EN));
        end
        tick();

        // Reset in the middle of a window discards everything, no tlast.
        got_q.delete();
        gate_flag = 1'b1;
        tick();
        push_beats(2, 32'h61);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h63;
        tick();
        @(negedge aclk);
        check("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mrst_m_tlast",  32'(m_axis_tlast),  32'd0);
        check("mrst_m_tdata",  m_axis_tdata,       32'd0);
        check("mrst_busy",     32'(busy),          32'd0);
        check("mrst_sts",      32'(sts_data),      32'd0);
        check("mrst_s_tready", 32'(s_axis_tready), 32'd0);
        tick();
        aresetn       = 1'b1;
        gate_flag     = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        @(negedge aclk);
        n_last = 0;
        foreach (got_q[i]) if (got_q[i].last) n_last++;
        check("mrst_no_tlast", 32'(n_last), 32'd0);
        check("mrst_o_idle", 32'(m_axis_tvalid), 32'd0);
        tick();
        clean = '{n: 3, base: 32'h70, bp: 1'b0, exp_beats: 3, exp_sts: 32'd3, exp_last_data: 32'h72};
        apply_vec(clean);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
